// File: rtl/ghash_aggregated_accumulator_if.sv
// ----------------------------------------------------------------------------
// ghash_aggregated_accumulator_if
// Block stream handshake feeding the aggregated GHASH accumulator.
//   i_data  : 128-bit block, bit 127 is GCM bit 0 (leftmost)
//   i_valid : i_data is presented
//   i_last  : block is the final block of the message
//   o_ready : accumulator takes the block on the edge where valid && ready
// master = block producer, slave = accumulator.
// ----------------------------------------------------------------------------
interface ghash_aggregated_accumulator_if #(
  parameter int NB_DATA = 128
);
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               i_last;
  logic               o_ready;

  modport master (output i_data, output i_valid, output i_last, input o_ready);
  modport slave  (input i_data, input i_valid, input i_last, output o_ready);
endinterface

// File: rtl/ghash_aggregated_accumulator.sv
// ----------------------------------------------------------------------------
// ghash_aggregated_accumulator
// GHASH over a block stream using aggregated reduction: up to MAX_POWER
// blocks are buffered, then
//   Y_new = (Y ^ X1)*H^k ^ X2*H^(k-1) ^ ... ^ Xk*H^1
// is formed with a single bit-serial GF(2^128) multiplier (128 cycles per
// product).
// Ports:
//   i_clock, i_reset  : clock, synchronous active-high reset
//   i_h_power_bus     : slot j (bits j*128 +: 128) holds H^(j+1)
//   i_powers_ready    : power bus valid; falling during a group aborts it
//   blk_if (slave)    : i_data / i_valid / i_last in, o_ready out
//   o_ghash           : GHASH of the last completed message
//   o_ghash_valid     : one-cycle pulse when o_ghash updates
// ----------------------------------------------------------------------------
module ghash_aggregated_accumulator #(
  parameter int NB_DATA      = 128,
  parameter int LOG2_NB_DATA = 8,
  parameter int MAX_POWER    = 4
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [MAX_POWER*NB_DATA-1:0]   i_h_power_bus,
  input  logic                           i_powers_ready,
  ghash_aggregated_accumulator_if.slave  blk_if,
  output logic [NB_DATA-1:0]             o_ghash,
  output logic                           o_ghash_valid
);

  if (NB_DATA != 128) begin : g_bad_nb_data
    $error("ghash_aggregated_accumulator: NB_DATA must be 128");
  end
  if (MAX_POWER < 1 || MAX_POWER > 16) begin : g_bad_max_power
    $error("ghash_aggregated_accumulator: MAX_POWER must be 1..16");
  end

  localparam int CNT_W = $clog2(MAX_POWER + 1);
  localparam int IDX_W = (MAX_POWER > 1) ? $clog2(MAX_POWER) : 1;
  localparam int BUF_D = 1 << IDX_W;
  localparam int BIT_W = $clog2(NB_DATA);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;

  localparam logic [NB_DATA-1:0] GF_R = {8'hE1, {(NB_DATA-8){1'b0}}};

  // One step of V = V*x in the GCM bit-reflected representation.
  function automatic logic [NB_DATA-1:0] gf_shift(input logic [NB_DATA-1:0] v);
    gf_shift = {1'b0, v[NB_DATA-1:1]} ^ (v[0] ? GF_R : '0);
  endfunction

  logic [1:0]              state_q,  state_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [CNT_W-1:0]        k_q,      k_d;
  logic [CNT_W-1:0]        j_q,      j_d;
  logic [LOG2_NB_DATA-1:0] bitcnt_q, bitcnt_d;
  logic                    last_q,   last_d;
  logic [NB_DATA-1:0]      y_q,      y_d;
  logic [NB_DATA-1:0]      s_q,      s_d;
  logic [NB_DATA-1:0]      z_q,      z_d;
  logic [NB_DATA-1:0]      v_q,      v_d;
  logic [NB_DATA-1:0]      ghash_q,  ghash_d;
  logic                    gv_q,     gv_d;

  logic [NB_DATA-1:0] buffer_q [BUF_D];
  logic [NB_DATA-1:0] h_pow    [BUF_D];
  logic               buf_wr;

  logic               ready_w;
  logic               accept;
  logic [CNT_W-1:0]   slot;
  logic [NB_DATA-1:0] operand;
  logic [NB_DATA-1:0] b_op;
  logic               b_bit;
  logic [NB_DATA-1:0] z_cur, v_cur, z_step, v_step;

  // Unused high slots read as zero so short buffers stay well defined.
  for (genvar g = 0; g < BUF_D; g++) begin : g_hpow
    if (g < MAX_POWER) begin : g_used
      assign h_pow[g] = i_h_power_bus[g*NB_DATA +: NB_DATA];
    end else begin : g_pad
      assign h_pow[g] = '0;
    end
  end

  assign ready_w        = (state_q == S_FILL) && i_powers_ready;
  assign blk_if.o_ready = ready_w;
  assign accept         = ready_w && blk_if.i_valid;
  assign o_ghash        = ghash_q;
  assign o_ghash_valid  = gv_q;

  // Multiplier datapath: the running Y folds into the first operand of the
  // group; bitcnt==0 restarts Z/V from the current operand.
  assign operand = (j_q == '0) ? (buffer_q[0] ^ y_q) : buffer_q[j_q[IDX_W-1:0]];
  assign slot    = k_q - j_q - 1'b1;
  assign b_op    = h_pow[slot[IDX_W-1:0]];
  assign b_bit   = b_op[BIT_W'(NB_DATA-1) - bitcnt_q[BIT_W-1:0]];
  assign v_cur   = (bitcnt_q == '0) ? operand : v_q;
  assign z_cur   = (bitcnt_q == '0) ? '0      : z_q;
  assign z_step  = b_bit ? (z_cur ^ v_cur) : z_cur;
  assign v_step  = gf_shift(v_cur);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    j_d      = j_q;
    bitcnt_d = bitcnt_q;
    last_d   = last_q;
    y_d      = y_q;
    s_d      = s_q;
    z_d      = z_q;
    v_d      = v_q;
    ghash_d  = ghash_q;
    gv_d     = 1'b0;
    buf_wr   = 1'b0;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          buf_wr = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MAX_POWER-1) || blk_if.i_last) begin
            k_d      = cnt_q + 1'b1;
            last_d   = blk_if.i_last;
            s_d      = '0;
            j_d      = '0;
            bitcnt_d = '0;
            state_d  = S_MULT;
          end
        end
      end
      S_MULT: begin
        if (!i_powers_ready) begin
          // Rekey: drop the group and the running hash.
          state_d = S_FILL;
          cnt_d   = '0;
          y_d     = '0;
          s_d     = '0;
        end else begin
          z_d      = z_step;
          v_d      = v_step;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LOG2_NB_DATA'(NB_DATA-1)) begin
            s_d      = s_q ^ z_step;
            bitcnt_d = '0;
            j_d      = j_q + 1'b1;
            if (j_q == k_q - 1'b1) begin
              state_d = S_UPD;
            end
          end
        end
      end
      S_UPD: begin
        state_d = S_FILL;
        cnt_d   = '0;
        if (!i_powers_ready) begin
          y_d = '0;
          s_d = '0;
        end else if (last_q) begin
          ghash_d = s_q;
          gv_d    = 1'b1;
          y_d     = '0;
        end else begin
          y_d = s_q;
        end
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and architectural hash state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= S_FILL;
      cnt_q    <= '0;
      k_q      <= '0;
      j_q      <= '0;
      bitcnt_q <= '0;
      last_q   <= 1'b0;
      y_q      <= '0;
      s_q      <= '0;
      ghash_q  <= '0;
      gv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      j_q      <= j_d;
      bitcnt_q <= bitcnt_d;
      last_q   <= last_d;
      y_q      <= y_d;
      s_q      <= s_d;
      ghash_q  <= ghash_d;
      gv_q     <= gv_d;
    end
  end

  // Block buffer and multiplier working registers.
  always_ff @(posedge i_clock) begin
    z_q <= z_d;
    v_q <= v_d;
    if (buf_wr) begin
      buffer_q[cnt_q[IDX_W-1:0]] <= blk_if.i_data;
    end
  end

endmodule

// File: tb/tb_ghash_aggregated_accumulator.sv
module tb_ghash_aggregated_accumulator;

  localparam logic [127:0] IDENT  = {1'b1, 127'b0};
  localparam logic [127:0] GF_R   = {8'hE1, 120'b0};
  localparam logic [127:0] NIST_H = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] NIST_C = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] NIST_L = 128'h00000000000000000000000000000080;
  localparam logic [127:0] NIST_G = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  logic         clk = 1'b0;
  logic         rst;
  logic         pr;
  logic [511:0] bus4;
  logic [127:0] bus1;
  logic [127:0] g4, g1;
  logic         gv4, gv1;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  typedef struct {
    logic [127:0] exp;
    bit           chk;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  ghash_aggregated_accumulator_if #(.NB_DATA(128)) if4 ();
  ghash_aggregated_accumulator_if #(.NB_DATA(128)) if1 ();

  ghash_aggregated_accumulator #(.NB_DATA(128), .LOG2_NB_DATA(8), .MAX_POWER(4)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_h_power_bus(bus4), .i_powers_ready(pr),
    .blk_if(if4), .o_ghash(g4), .o_ghash_valid(gv4));

  ghash_aggregated_accumulator #(.NB_DATA(128), .LOG2_NB_DATA(8), .MAX_POWER(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_h_power_bus(bus1), .i_powers_ready(pr),
    .blk_if(if1), .o_ghash(g1), .o_ghash_valid(gv1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = x;
    for (int i = 0; i < 128; i++) begin
      if (y[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end
    return z;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? if4.o_ready : if1.o_ready;
  endfunction

  task automatic drive(input int d, input logic [127:0] data, input logic v, input logic last);
    if (d == 0) begin
      if4.i_data = data; if4.i_valid = v; if4.i_last = last;
    end else begin
      if1.i_data = data; if1.i_valid = v; if1.i_last = last;
    end
  endtask

  // Presents one block, waits (bounded) for the accept edge, and when the
  // block ends a checked message queues the expected result.
  task automatic send(input int d, input logic [127:0] data, input logic last,
                      input bit push, input logic [127:0] expv, input int lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    drive(d, data, 1'b1, last);
    while (!rdy(d) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) begin
      check_int("accept timeout", n, 0);
      drive(d, '0, 1'b0, 1'b0);
      return;
    end
    if (push) begin
      e.exp = expv;
      e.chk = (lat > 0);
      e.acc = cyc + 1;
      e.lat = lat;
      if (d == 0) q4.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    drive(d, '0, 1'b0, 1'b0);
  endtask

  task automatic measure_low(input int d, input string nm, input int exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy(d) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check_int(nm, n, exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    check_int("results outstanding", q4.size() + q1.size(), 0);
  endtask

  // Result monitors.
  always @(negedge clk) begin
    exp_t e;
    if (gv4 === 1'b1) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut4 unexpected pulse: got ghash %h want no pulse", g4);
      end else begin
        e = q4.pop_front();
        check("dut4 ghash", g4, e.exp);
        if (e.chk) check_int("dut4 latency", cyc - e.acc, e.lat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (gv1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut1 unexpected pulse: got ghash %h want no pulse", g1);
      end else begin
        e = q1.pop_front();
        check("dut1 ghash", g1, e.exp);
        if (e.chk) check_int("dut1 latency", cyc - e.acc, e.lat);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] h2, h3, h4;
    h2 = gf_mul(NIST_H, NIST_H);
    h3 = gf_mul(h2, NIST_H);
    h4 = gf_mul(h3, NIST_H);

    rst = 1'b1;
    pr  = 1'b0;
    bus4 = {4{IDENT}};
    bus1 = IDENT;
    drive(0, '0, 1'b0, 1'b0);
    drive(1, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_int("reset ready", int'(if4.o_ready), 0);
    check("reset ghash", g4, '0);
    check_int("reset pulse", int'(gv4), 0);
    pr = 1'b1;
    #1;
    check_int("ready with powers", int'(if4.o_ready), 1);

    // Identity powers, one group of 3.
    send(0, 128'h1, 1'b0, 1'b0, '0, 0);
    send(0, 128'h2, 1'b0, 1'b0, '0, 0);
    send(0, 128'h4, 1'b1, 1'b1, 128'h7, 385);
    drain();

    // Six blocks: groups of 4 and 2.
    send(0, 128'h1, 1'b0, 1'b0, '0, 0);
    send(0, 128'h2, 1'b0, 1'b0, '0, 0);
    send(0, 128'h3, 1'b0, 1'b0, '0, 0);
    send(0, 128'h4, 1'b0, 1'b0, '0, 0);
    measure_low(0, "busy after group of 4", 513);
    send(0, 128'h5, 1'b0, 1'b0, '0, 0);
    send(0, 128'h6, 1'b1, 1'b1, 128'h7, 257);
    measure_low(0, "busy after group of 2", 257);
    drain();

    // NIST test case 2 with real powers, MAX_POWER=4 and MAX_POWER=1.
    bus4 = {h4, h3, h2, NIST_H};
    bus1 = NIST_H;
    send(0, NIST_C, 1'b0, 1'b0, '0, 0);
    send(0, NIST_L, 1'b1, 1'b1, NIST_G, 257);
    drain();
    send(1, NIST_C, 1'b0, 1'b0, '0, 0);
    send(1, NIST_L, 1'b1, 1'b1, NIST_G, 129);
    drain();

    // Zero powers, then identity: second message sees only its own blocks.
    bus4 = '0;
    send(0, 128'hdeadbeef, 1'b0, 1'b0, '0, 0);
    send(0, 128'h12345678, 1'b0, 1'b0, '0, 0);
    send(0, 128'hcafef00d, 1'b1, 1'b1, '0, 385);
    drain();
    bus4 = {4{IDENT}};
    send(0, 128'h11, 1'b0, 1'b0, '0, 0);
    send(0, 128'h22, 1'b1, 1'b1, 128'h33, 257);
    drain();

    // Rekey abort during the second non-final group.
    send(0, 128'h1, 1'b0, 1'b0, '0, 0);
    send(0, 128'h2, 1'b0, 1'b0, '0, 0);
    send(0, 128'h4, 1'b0, 1'b0, '0, 0);
    send(0, 128'h8, 1'b0, 1'b0, '0, 0);
    measure_low(0, "busy before abort", 513);
    send(0, 128'h10, 1'b0, 1'b0, '0, 0);
    send(0, 128'h20, 1'b0, 1'b0, '0, 0);
    send(0, 128'h40, 1'b0, 1'b0, '0, 0);
    send(0, 128'h80, 1'b0, 1'b0, '0, 0);
    repeat (50) @(negedge clk);
    pr = 1'b0;
    repeat (3) @(negedge clk);
    check("abort keeps ghash", g4, 128'h33);
    pr = 1'b1;
    #1;
    check_int("ready after abort", int'(if4.o_ready), 1);
    send(0, 128'h55, 1'b1, 1'b1, 128'h55, 129);
    drain();

    // Reset in the middle of a product with a block held valid.
    send(0, 128'h77, 1'b1, 1'b0, '0, 0);
    repeat (30) @(negedge clk);
    drive(0, 128'h99, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_int("mid reset ready", int'(if4.o_ready), 1);
    check("mid reset ghash", g4, '0);
    check_int("mid reset pulse", int'(gv4), 0);
    rst = 1'b0;
    drive(0, '0, 1'b0, 1'b0);
    send(0, 128'h1234, 1'b1, 1'b1, 128'h1234, 129);
    drain();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ghash_aggregated_accumulator.md
Name: ghash_aggregated_accumulator

Overview:
- Downstream consumer of the H-power bus produced by the subkey power generator.
- Computes GHASH (NIST SP 800-38D) over a stream of 128-bit blocks, MAX_POWER blocks per aggregation group: Y_new = (Y ^ X1)·H^k ^ X2·H^(k-1) ^ … ^ Xk·H^1.
- Uses one internal bit-serial GF(2^128) multiplier (128 cycles per product).
- Feeds the GCM tag stage.

Parameters:
- NB_DATA, 128, block width; any other value is an illegal configuration.
- LOG2_NB_DATA, 8, width of the bit-serial cycle counter.
- MAX_POWER, 4, number of H powers on the bus, which is also the maximum group size; range 1..16.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_h_power_bus  in  MAX_POWER*NB_DATA  slot j (bits j*128 +: 128) holds H^(j+1).
- i_powers_ready  in  1  bus is valid and stable while high.
- i_data  in  NB_DATA  input block; bit 127 is GCM bit 0 (leftmost).
- i_valid  in  1  i_data is presented.
- i_last  in  1  qualifies i_data as the final block of the message.
- o_ready  out  1  block accepted on the edge where i_valid && o_ready.
- o_ghash  out  NB_DATA  GHASH result of the last completed message.
- o_ghash_valid  out  1  one-cycle pulse when o_ghash updates.

Behaviour:
- Reset values: o_ready=0, o_ghash=0, o_ghash_valid=0. Internally Y=0, S=0, cnt=0, state=S_FILL.
- o_ready = (state==S_FILL) && i_powers_ready. This is the only combinational output.
- S_FILL:
  - On accept, store i_data into buffer[cnt] and increment cnt.
  - If cnt==MAX_POWER-1 or i_last: set k=cnt+1, latch last_flag=i_last, clear S, set j=0, bitcnt=0, go to S_MULT.
- S_MULT (one product per operand j=0..k-1):
  - Operand A = buffer[0]^Y when j==0, else buffer[j]. Multiplier B = H^(k-j).
  - GCM Algorithm 1, one multiplier bit per cycle, starting at bit 127 (Z=0, V=A):
    - if B bit set, Z^=V;
    - V = V>>1, XOR 0xE1<<120 if the shifted-out bit was 1.
  - After 128 cycles: S^=Z, j++, bitcnt=0.
  - After product k-1, go to S_UPD.
  - State duration is exactly 128*k cycles.
- S_UPD (1 cycle):
  - If last_flag: o_ghash<=S, o_ghash_valid<=1 on the next edge, Y<=0.
  - Else: Y<=S.
  - In both cases cnt<=0 and go to S_FILL.
- Latency: o_ghash_valid is high on edge 128*k+1 after the accepting edge of the group-closing block. o_ready rises on that same edge if i_powers_ready is high.
- Throughput: at most one block accepted per cycle in S_FILL. o_ready stays low throughout S_MULT and S_UPD.
- A short final group (k<MAX_POWER) uses H^k..H^1 only; upper slots are ignored.
- MAX_POWER=1 degenerates to plain Horner GHASH: every block closes a group, 129 cycles per block.
- i_powers_ready low in S_FILL: no accepts; buffered blocks and Y are kept.
- i_powers_ready falls in S_MULT or S_UPD (rekey): abort. Next edge: state=S_FILL, cnt=0, Y=0, S=0, no o_ghash_valid, o_ghash unchanged.
- i_reset has priority over everything, including mid-operation; the state is restored in one edge.
- A message with an empty group is impossible; a message always contains at least one block.
- i_last with cnt==MAX_POWER-1 closes a single full group, counted once.

Test Plan:
- H^j = 0x8000…0 for all j (field identity), send X1=0x1, X2=0x2, X3=0x4, i_last on X3, MAX_POWER=4 -> single group k=3; o_ghash=0x…07; o_ghash_valid on edge 385 after the X3 accept; exactly one pulse.
- Identity powers, 6 blocks 0x01..0x06 with i_last on the 6th (groups of 4 and 2) -> o_ghash=0x…07 (XOR of all blocks); o_ready low for 512+1 cycles after block 4, then for 256+1 cycles after block 6.
- H from NIST GCM test case 2 (66e94bd4ef8a2c3b884cfa59ca342b2e), powers from a bit-accurate model, C block plus length block 0x…0080 -> o_ghash matches the published GHASH for that case. Repeat with MAX_POWER=1 and check the result is identical.
- All H powers = 0, any three blocks with i_last -> o_ghash=0; a second message with identity powers returns only its own XOR (Y cleared between messages).
- Drop i_powers_ready 50 cycles into S_MULT -> no o_ghash_valid, o_ghash keeps its previous value, o_ready high the cycle i_powers_ready returns; a new message then computes from Y=0.
- Assert i_reset mid-S_MULT with i_valid held high -> next cycle o_ready=(i_powers_ready), o_ghash=0, no pulse; a subsequent one-block message with identity H gives o_ghash=X1.
